// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: per-stage stall vector, timed flush pulse and a
// valid/ready redirect PC to fetch. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int STAGES       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STAGES-1:0]     stall_req,
  input  logic                  flush_req,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  redirect_ready,
  output logic [STAGES-1:0]     stall,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
`ifdef PIPE_CTRL_PERF_EN
  output logic                  busy,
  output logic [31:0]           perf_stall_cycles,
  output logic [15:0]           perf_flush_count
`else
  output logic                  busy
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t                  state_r;
  state_t                  state_next_s;
  logic [3:0]              cnt_r;
  logic [3:0]              cnt_next_s;
  logic [ADDR_WIDTH-1:0]   pc_r;
  logic [ADDR_WIDTH-1:0]   pc_next_s;
  logic                    flush_r;
  logic                    redirect_valid_r;
  logic                    busy_r;
  logic [STAGES-1:0]       stall_chain_s;
  logic [STAGES-1:0]       stall_s;

  // Suffix-OR: a stall in stage k freezes every stage at or below k.
  always_comb begin
    logic acc_s;
    acc_s = 1'b0;
    stall_chain_s = {STAGES{1'b0}};
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc_s = acc_s | stall_req[i];
      stall_chain_s[i] = acc_s;
    end
  end

  // Stall vector: masked while flushing and while reset is held.
  always_comb begin
    if (rst || (state_r == ST_FLUSH)) begin
      stall_s = {STAGES{1'b0}};
    end else begin
      stall_s = stall_chain_s;
    end
  end

  // Next-state logic; a new flush_req preempts FLUSH and REDIRECT alike.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    pc_next_s    = pc_r;
    case (state_r)
      ST_IDLE: begin
        if (flush_req) begin
          pc_next_s    = flush_pc;
          cnt_next_s   = CNT_RELOAD;
          state_next_s = ST_FLUSH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush_req) begin
          pc_next_s    = flush_pc;
          cnt_next_s   = CNT_RELOAD;
          state_next_s = ST_FLUSH;
        end else if (cnt_r == 4'd0) begin
          state_next_s = ST_REDIRECT;
        end else begin
          cnt_next_s   = cnt_r - 4'd1;
          state_next_s = ST_FLUSH;
        end
      end
      ST_REDIRECT: begin
        if (flush_req) begin
          pc_next_s    = flush_pc;
          cnt_next_s   = CNT_RELOAD;
          state_next_s = ST_FLUSH;
        end else if (redirect_valid_r && redirect_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_REDIRECT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
        pc_next_s    = pc_r;
      end
    endcase
  end

  // State, counter, latched PC and registered outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      cnt_r            <= 4'd0;
      pc_r             <= {ADDR_WIDTH{1'b0}};
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      state_r          <= state_next_s;
      cnt_r            <= cnt_next_s;
      pc_r             <= pc_next_s;
      flush_r          <= (state_next_s == ST_FLUSH);
      redirect_valid_r <= (state_next_s == ST_REDIRECT);
      busy_r           <= (state_next_s != ST_IDLE);
    end
  end

  assign stall          = stall_s;
  assign flush          = flush_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = pc_r;
  assign busy           = busy_r;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_r;
  logic [15:0] perf_flush_r;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 16'd0;
    end else begin
      if (|stall_s) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
      if (flush_req) begin
        perf_flush_r <= perf_flush_r + 16'd1;
      end else begin
        perf_flush_r <= perf_flush_r;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_r;
  assign perf_flush_count  = perf_flush_r;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (STAGES=5, FLUSH_CYCLES=2).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  stall_req = 5'b00000;
  logic        flush_req = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        redirect_ready = 1'b0;
  logic [4:0]  stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.STAGES(5), .FLUSH_CYCLES(2), .ADDR_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .stall_req(stall_req),
    .flush_req(flush_req),
    .flush_pc(flush_pc),
    .redirect_ready(redirect_ready),
    .stall(stall),
    .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
`ifdef PIPE_CTRL_PERF_EN
    .busy(busy),
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count(perf_flush_count)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall_req = 5'b10101;
    flush_req = 1'b0;
    step();
    step();
    #1;
    checks++;
    if ({stall, flush, redirect_valid, busy} !== 8'h00 || redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs stall=%b flush=%b rv=%b busy=%b pc=%h want all 0", stall, flush, redirect_valid, busy, redirect_pc);
    end
    rst = 1'b0;
    stall_req = 5'b00100;
    #1;
    checks++;
    if (stall !== 5'b00111) begin
      errors++;
      $display("FAIL stall_prop_00100 got %b want 00111", stall);
    end
    stall_req = 5'b00000;
    #1;
    checks++;
    if (stall !== 5'b00000) begin
      errors++;
      $display("FAIL stall_prop_zero got %b want 00000", stall);
    end
    stall_req = 5'b10000;
    #1;
    checks++;
    if (stall !== 5'b11111) begin
      errors++;
      $display("FAIL stall_prop_10000 got %b want 11111", stall);
    end
    stall_req = 5'b01010;
    #1;
    checks++;
    if (stall !== 5'b01111) begin
      errors++;
      $display("FAIL stall_prop_01010 got %b want 01111", stall);
    end
    stall_req = 5'b00001;
    #1;
    checks++;
    if (stall !== 5'b00001) begin
      errors++;
      $display("FAIL stall_prop_00001 got %b want 00001", stall);
    end
    stall_req = 5'b00000;
    step();
  endtask

  task automatic test_basic_flush();
    redirect_ready = 1'b0;
    flush_req = 1'b1;
    flush_pc = 32'h8000_0180;
    step();
    flush_req = 1'b0;
    flush_pc = 32'h1111_1111;
    checks++;
    if (flush !== 1'b1 || busy !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle1 flush=%b busy=%b rv=%b want 1 1 0", flush, busy, redirect_valid);
    end
    step();
    checks++;
    if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle2 flush=%b rv=%b want 1 0", flush, redirect_valid);
    end
    step();
    checks++;
    if (flush !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0180) begin
      errors++;
      $display("FAIL redirect_rise flush=%b rv=%b pc=%h want 0 1 80000180", flush, redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_handshake();
    for (int i = 0; i < 3; i++) begin
      flush_pc = 32'hDEAD_0000 + 32'(i);
      step();
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0180 || busy !== 1'b1) begin
        errors++;
        $display("FAIL redirect_hold%0d rv=%b pc=%h busy=%b want 1 80000180 1", i, redirect_valid, redirect_pc, busy);
      end
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    checks++;
    if (redirect_valid !== 1'b0 || busy !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL handshake_idle rv=%b busy=%b flush=%b want 0 0 0", redirect_valid, busy, flush);
    end
  endtask

  task automatic test_stall_masked();
    stall_req = 5'b11111;
    flush_req = 1'b1;
    flush_pc = 32'h0000_4000;
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (flush !== 1'b1 || stall !== 5'b00000) begin
        errors++;
        $display("FAIL stall_masked%0d flush=%b stall=%b want 1 00000", i, flush, stall);
      end
      step();
    end
    checks++;
    if (redirect_valid !== 1'b1 || stall !== 5'b11111) begin
      errors++;
      $display("FAIL stall_in_redirect rv=%b stall=%b want 1 11111", redirect_valid, stall);
    end
    stall_req = 5'b00000;
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
  endtask

  task automatic test_nested_flush();
    flush_req = 1'b1;
    flush_pc = 32'h1234_5678;
    step();
    flush_req = 1'b0;
    step();
    flush_req = 1'b1;
    flush_pc = 32'hBFC0_0000;
    step();
    flush_req = 1'b0;
    flush_pc = 32'h0;
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL nested_ext1 flush=%b want 1", flush);
    end
    step();
    checks++;
    if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL nested_ext2 flush=%b rv=%b want 1 0", flush, redirect_valid);
    end
    step();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0000) begin
      errors++;
      $display("FAIL nested_pc rv=%b pc=%h want 1 bfc00000", redirect_valid, redirect_pc);
    end
    redirect_ready = 1'b1;
    flush_req = 1'b1;
    flush_pc = 32'hCAFE_0000;
    step();
    flush_req = 1'b0;
    checks++;
    if (flush !== 1'b1 || busy !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL preempt_redirect flush=%b busy=%b rv=%b want 1 1 0", flush, busy, redirect_valid);
    end
    step();
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL preempt_flush2 flush=%b want 1", flush);
    end
    step();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hCAFE_0000) begin
      errors++;
      $display("FAIL preempt_pc rv=%b pc=%h want 1 cafe0000", redirect_valid, redirect_pc);
    end
    step();
    redirect_ready = 1'b0;
    checks++;
    if (redirect_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL min_latency_idle rv=%b busy=%b want 0 0", redirect_valid, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    flush_req = 1'b1;
    flush_pc = 32'h0000_0ABC;
    step();
    flush_req = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (flush !== 1'b0 || busy !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_flush flush=%b busy=%b rv=%b pc=%h want 0 0 0 0", flush, busy, redirect_valid, redirect_pc);
    end
    rst = 1'b0;
    flush_req = 1'b1;
    flush_pc = 32'h0000_0DEF;
    step();
    flush_req = 1'b0;
    step();
    step();
    checks++;
    if (redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_redirect rv=%b want 1", redirect_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (redirect_valid !== 1'b0 || busy !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_redirect rv=%b busy=%b flush=%b want 0 0 0", redirect_valid, busy, flush);
    end
    step();
    checks++;
    if (busy !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%b flush=%b want 0 0", busy, flush);
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    step();
    rst = 1'b0;
    stall_req = 5'b00010;
    repeat (7) step();
    stall_req = 5'b00000;
    flush_req = 1'b1;
    flush_pc = 32'h0000_0100;
    step();
    flush_req = 1'b0;
    redirect_ready = 1'b1;
    repeat (3) step();
    redirect_ready = 1'b0;
    checks++;
    if (perf_stall_cycles !== 32'd7 || perf_flush_count !== 16'd1) begin
      errors++;
      $display("FAIL perf_counters stall=%0d flush=%0d want 7 1", perf_stall_cycles, perf_flush_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_flush();
    test_handshake();
    test_stall_masked();
    test_nested_flush();
    test_reset_mid_op();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
